// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage pipelined barrel shifter for the operand-2 path.
// It supports LSL/LSR/ASR/ROR with immediate or register amounts and the
// #0 special encodings. Valid/ready handshakes are used on both sides, with
// backpressure and a synchronous flush.
// Optional feature macro: SHIFT_UNIT_CARRY_EN. When it is defined, carry-out
// and the RRX remap of immediate ROR #0 are compiled in. When it is not
// defined, out_carry is 0 and ROR #0 leaves the operand unchanged.
module shift_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sh,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_regamt,
  input  logic             in_bypass,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int LW = $clog2(WIDTH);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Amount classes resolved in decode; ROR never produces CLS_OVER because
  // register ROR amounts are reduced modulo WIDTH.
  localparam logic [1:0] CLS_ZERO  = 2'd0;
  localparam logic [1:0] CLS_RANGE = 2'd1;
  localparam logic [1:0] CLS_EXACT = 2'd2;
  localparam logic [1:0] CLS_OVER  = 2'd3;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_data_r;
  logic [1:0]       s1_sh_r;
  logic [1:0]       s1_cls_r;
  logic [LW-1:0]    s1_n_r;
  logic             s1_bypass_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_carry_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [1:0]       dec_cls_s;
  logic             dec_rrx_s;
  logic             c_flag_s;
  logic             rrx_s;
  logic [LW-1:0]    neg_n_s;
  logic [LW-1:0]    nm1_s;
  logic [WIDTH-1:0] res_s;
  logic             car_raw_s;
  logic             car_out_s;

`ifdef SHIFT_UNIT_CARRY_EN
  logic s1_carry_r;
  logic s1_rrx_r;
  assign c_flag_s  = s1_carry_r;
  assign rrx_s     = s1_rrx_r;
  assign car_out_s = car_raw_s;
`else
  logic unused_in_carry_s;
  logic unused_car_s;
  logic unused_dec_rrx_s;
  assign c_flag_s          = 1'b0;
  assign rrx_s             = 1'b0;
  assign car_out_s         = 1'b0;
  assign unused_in_carry_s = in_carry;
  assign unused_car_s      = car_raw_s;
  assign unused_dec_rrx_s  = dec_rrx_s;
`endif

  // Stage 2 (output register) moves when empty or drained; stage 1 follows it.
  assign s2_adv_s   = ~out_valid_r | out_ready;
  assign s1_adv_s   = s2_adv_s;
  assign in_ready_s = ~s1_valid_r | s1_adv_s;
  assign accept_s   = in_valid & in_ready_s & ~flush;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_carry = out_carry_r;

  // Decode: resolve the amount class and apply the immediate #0 remaps.
  always_comb begin
    dec_cls_s = CLS_ZERO;
    dec_rrx_s = 1'b0;
    if (in_regamt) begin
      if (in_amt == {AMT_W{1'b0}}) begin
        dec_cls_s = CLS_ZERO;
      end else if (in_sh == SH_ROR) begin
        // A nonzero multiple of WIDTH rotates back to the original operand.
        if (in_amt[LW-1:0] == {LW{1'b0}}) begin
          dec_cls_s = CLS_EXACT;
        end else begin
          dec_cls_s = CLS_RANGE;
        end
      end else if (in_amt < AMT_W'(WIDTH)) begin
        dec_cls_s = CLS_RANGE;
      end else if (in_amt == AMT_W'(WIDTH)) begin
        dec_cls_s = CLS_EXACT;
      end else begin
        dec_cls_s = CLS_OVER;
      end
    end else if (in_amt[LW-1:0] != {LW{1'b0}}) begin
      dec_cls_s = CLS_RANGE;
    end else begin
      case (in_sh)
        SH_LSL:  dec_cls_s = CLS_ZERO;
        SH_LSR:  dec_cls_s = CLS_EXACT;
        SH_ASR:  dec_cls_s = CLS_EXACT;
        SH_ROR: begin
          dec_cls_s = CLS_ZERO;
`ifdef SHIFT_UNIT_CARRY_EN
          dec_rrx_s = 1'b1;
`endif
        end
        default: dec_cls_s = CLS_ZERO;
      endcase
    end
  end

  // Stage 1 register: valid bit and decoded operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= {WIDTH{1'b0}};
      s1_sh_r     <= 2'b00;
      s1_cls_r    <= CLS_ZERO;
      s1_n_r      <= {LW{1'b0}};
      s1_bypass_r <= 1'b0;
`ifdef SHIFT_UNIT_CARRY_EN
      s1_carry_r  <= 1'b0;
      s1_rrx_r    <= 1'b0;
`endif
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (in_ready_s) begin
        s1_valid_r <= in_valid;
      end
      if (accept_s) begin
        s1_data_r   <= in_data;
        s1_sh_r     <= in_sh;
        s1_cls_r    <= dec_cls_s;
        s1_n_r      <= in_amt[LW-1:0];
        s1_bypass_r <= in_bypass;
`ifdef SHIFT_UNIT_CARRY_EN
        s1_carry_r  <= in_carry;
        s1_rrx_r    <= dec_rrx_s;
`endif
      end
    end
  end

  assign neg_n_s = {LW{1'b0}} - s1_n_r;
  assign nm1_s   = s1_n_r - {{(LW-1){1'b0}}, 1'b1};

  // Execute: shift result and carry-out from the decoded stage-1 operation.
  always_comb begin
    res_s     = s1_data_r;
    car_raw_s = c_flag_s;
    if (s1_bypass_r) begin
      res_s     = s1_data_r;
      car_raw_s = c_flag_s;
    end else if (rrx_s) begin
      res_s     = {c_flag_s, s1_data_r[WIDTH-1:1]};
      car_raw_s = s1_data_r[0];
    end else begin
      case (s1_cls_r)
        CLS_ZERO: begin
          res_s     = s1_data_r;
          car_raw_s = c_flag_s;
        end
        CLS_RANGE: begin
          case (s1_sh_r)
            SH_LSL: begin
              res_s     = s1_data_r << s1_n_r;
              car_raw_s = s1_data_r[neg_n_s];
            end
            SH_LSR: begin
              res_s     = s1_data_r >> s1_n_r;
              car_raw_s = s1_data_r[nm1_s];
            end
            SH_ASR: begin
              res_s     = $unsigned($signed(s1_data_r) >>> s1_n_r);
              car_raw_s = s1_data_r[nm1_s];
            end
            SH_ROR: begin
              res_s     = (s1_data_r >> s1_n_r) | (s1_data_r << neg_n_s);
              car_raw_s = s1_data_r[nm1_s];
            end
            default: begin
              res_s     = s1_data_r;
              car_raw_s = c_flag_s;
            end
          endcase
        end
        CLS_EXACT, CLS_OVER: begin
          case (s1_sh_r)
            SH_LSL: begin
              res_s     = {WIDTH{1'b0}};
              car_raw_s = (s1_cls_r == CLS_EXACT) ? s1_data_r[0] : 1'b0;
            end
            SH_LSR: begin
              res_s     = {WIDTH{1'b0}};
              car_raw_s = (s1_cls_r == CLS_EXACT) ? s1_data_r[WIDTH-1] : 1'b0;
            end
            SH_ASR: begin
              res_s     = {WIDTH{s1_data_r[WIDTH-1]}};
              car_raw_s = s1_data_r[WIDTH-1];
            end
            SH_ROR: begin
              res_s     = s1_data_r;
              car_raw_s = s1_data_r[WIDTH-1];
            end
            default: begin
              res_s     = s1_data_r;
              car_raw_s = c_flag_s;
            end
          endcase
        end
        default: begin
          res_s     = s1_data_r;
          car_raw_s = c_flag_s;
        end
      endcase
    end
  end

  // Stage 2 register: output valid, result and carry; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_carry_r <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_r <= 1'b0;
      end else if (s2_adv_s) begin
        out_valid_r <= s1_valid_r;
      end
      if (s2_adv_s & s1_valid_r & ~flush) begin
        out_data_r  <= res_s;
        out_carry_r <= car_out_s;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe.
// The driver pushes hand-computed results into a queue when a request is accepted.
// The monitor pops from that queue and compares on each output handshake.
module tb_shift_unit_pipe;
  localparam int WIDTH = 32;
  localparam int AMT_W = 8;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

`ifdef SHIFT_UNIT_CARRY_EN
  localparam logic [WIDTH-1:0] ROR0_EXP = 32'h8000_0001;
`else
  localparam logic [WIDTH-1:0] ROR0_EXP = 32'h0000_0003;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = 32'h0;
  logic [1:0]       in_sh = 2'b00;
  logic [AMT_W-1:0] in_amt = 8'h0;
  logic             in_regamt = 1'b0;
  logic             in_bypass = 1'b0;
  logic             in_carry = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  logic [WIDTH:0] sb[$];
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_d = 32'h0;
  logic             held_c = 1'b0;

  logic [WIDTH-1:0] bp_d [4] = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004};
  logic [WIDTH-1:0] bp_e [4] = '{32'h8000_0002, 32'h8000_0004, 32'h8000_0006, 32'h8000_0008};

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sh(in_sh), .in_amt(in_amt), .in_regamt(in_regamt),
    .in_bypass(in_bypass), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry)
  );

  function automatic logic ec(input logic c);
`ifdef SHIFT_UNIT_CARRY_EN
    return c;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_word(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one request and hold it until accepted; push the expected result.
  task automatic send(input logic [1:0] sh, input logic [AMT_W-1:0] amt, input logic regamt,
                      input logic bypass, input logic c, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] ed, input logic ecar);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_sh = sh; in_amt = amt; in_regamt = regamt;
    in_bypass = bypass; in_carry = c; in_data = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      sb.push_back({ec(ecar), ed});
      n_acc++;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 100 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_int("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compare each output handshake and check stability during stalls.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && stall_prev && out_valid) begin
        check_word("stall_data", out_data, held_d);
        check_bit("stall_carry", out_carry, held_c);
      end
      if (rst_n && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", out_data);
        end else begin
          e = sb.pop_front();
          check_word("result_data", out_data, e[WIDTH-1:0]);
          check_bit("result_carry", out_carry, e[WIDTH]);
        end
      end
      stall_prev = rst_n && out_valid && !out_ready && !flush;
      held_d = out_data;
      held_c = out_carry;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_word("reset_out_data", out_data, 32'h0);
    check_bit("reset_out_carry", out_carry, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("idle_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Latency: presented after edge k, accepted at k+1, valid after k+2.
    send(LSL, 8'd4, 1'b0, 1'b0, 1'b0, 32'h8000_000F, 32'h0000_00F0, 1'b0);
    idle();
    check_bit("latency_edge1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_bit("latency_edge2", out_valid, 1'b1);

    // Directed vectors, back to back.
    send(LSR, 8'd0,  1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'h0000_0000, 1'b1);
    send(LSR, 8'd33, 1'b1, 1'b0, 1'b0, 32'h8000_0001, 32'h0000_0000, 1'b0);
    send(ASR, 8'd40, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    send(ROR, 8'd64, 1'b1, 1'b0, 1'b0, 32'h8000_0001, 32'h8000_0001, 1'b1);
    send(ROR, 8'd0,  1'b0, 1'b0, 1'b1, 32'h0000_0003, ROR0_EXP,      1'b1);
    send(LSL, 8'd5,  1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1);
    send(LSL, 8'd0,  1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
    send(LSR, 8'd4,  1'b0, 1'b0, 1'b0, 32'h0000_001F, 32'h0000_0001, 1'b1);
    send(ASR, 8'd4,  1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'hF800_0001, 1'b0);
    send(ROR, 8'd8,  1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h7812_3456, 1'b0);
    send(LSL, 8'd32, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1);
    send(LSL, 8'd33, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    send(ASR, 8'd32, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
    send(ROR, 8'd36, 1'b1, 1'b0, 1'b0, 32'h0000_000F, 32'hF000_0000, 1'b1);
    send(LSL, 8'd0,  1'b1, 1'b0, 1'b1, 32'h0000_0055, 32'h0000_0055, 1'b1);
    send(LSL, 8'h24, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0010, 1'b0);
    send(LSL, 8'd31, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h8000_0000, 1'b1);
    send(LSR, 8'd32, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1);
    send(ASR, 8'd0,  1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    send(ROR, 8'd0,  1'b1, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_00F0, 1'b1);
    idle();
    wait_drain();

    // Backpressure: four requests against a 5-cycle output stall.
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(LSL, 8'd1, 1'b0, 1'b0, 1'b0, bp_d[i], bp_e[i], 1'b1);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        check_int("bp_accepts", n_acc, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with both stages full plus a request presented in the flush cycle.
    out_ready = 1'b0;
    send(LSR, 8'd4, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    send(LSL, 8'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0004, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    check_bit("flush_out_valid", out_valid, 1'b0);
    check_bit("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_bit("flush_no_stale", out_valid, 1'b0);

    // Reset pulsed mid-stream while a result is on the output.
    send(ROR, 8'd8, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h7812_3456, 1'b0);
    send(LSR, 8'd4, 1'b0, 1'b0, 1'b0, 32'h0000_001F, 32'h0000_0001, 1'b1);
    idle();
    check_bit("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async_reset_valid", out_valid, 1'b0);
    check_word("async_reset_data", out_data, 32'h0);
    check_bit("async_reset_carry", out_carry, 1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("post_reset_empty", out_valid, 1'b0);
    send(ASR, 8'd33, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle();
    check_bit("post_reset_lat1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_bit("post_reset_lat2", out_valid, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
